// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer inputs, stall back-pressure and CDB broadcast bundle.
interface cdb_arbiter_if #(parameter int ROB_WIDTH = 4);
    logic                 readyIn;
    logic                 clear;
    logic                 aluFlag;
    logic [ROB_WIDTH-1:0] aluId;
    logic [31:0]          aluValue;
    logic                 aluStall;
    logic                 loadFlag;
    logic [ROB_WIDTH-1:0] loadId;
    logic [31:0]          loadValue;
    logic                 loadStall;
    logic                 cdbFlag;
    logic [ROB_WIDTH-1:0] cdbId;
    logic [31:0]          cdbValue;
    modport master (
        output readyIn, clear, aluFlag, aluId, aluValue, loadFlag, loadId, loadValue,
        input  aluStall, loadStall, cdbFlag, cdbId, cdbValue
    );
    modport slave (
        input  readyIn, clear, aluFlag, aluId, aluValue, loadFlag, loadId, loadValue,
        output aluStall, loadStall, cdbFlag, cdbId, cdbValue
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the ROB write-back port between ALU and load results.
module cdb_arbiter #(
    parameter int ROB_WIDTH   = 4,
    parameter int QUEUE_DEPTH = 2
) (
    input logic           clockIn,
    input logic           resetIn,
    cdb_arbiter_if.slave  bus
);
    localparam int   PW   = $clog2(QUEUE_DEPTH);
    localparam int   CW   = PW + 1;
    localparam logic LOAD = 1'b1;

    // source index 0 is the ALU, 1 is the load path
    logic [ROB_WIDTH-1:0] r_q_id  [2][QUEUE_DEPTH];
    logic [31:0]          r_q_val [2][QUEUE_DEPTH];
    logic [PW-1:0]        r_head  [2];
    logic [PW-1:0]        r_tail  [2];
    logic [CW-1:0]        r_cnt   [2];
    logic                 r_last;
    logic                 r_cdb_flag;
    logic [ROB_WIDTH-1:0] r_cdb_id;
    logic [31:0]          r_cdb_val;

    logic [1:0]           w_flag, w_full, w_head_ok, w_in, w_cand, w_grant, w_pop, w_push;
    logic [ROB_WIDTH-1:0] w_in_id   [2];
    logic [ROB_WIDTH-1:0] w_cand_id [2];
    logic [31:0]          w_in_val  [2];
    logic [31:0]          w_cand_val[2];
    logic                 w_win;

    always_comb begin
        w_flag      = {bus.loadFlag, bus.aluFlag};
        w_in_id[0]  = bus.aluId;
        w_in_id[1]  = bus.loadId;
        w_in_val[0] = bus.aluValue;
        w_in_val[1] = bus.loadValue;
        for (int s = 0; s < 2; s++) begin
            w_full[s]     = r_cnt[s] == CW'(QUEUE_DEPTH);
            w_head_ok[s]  = r_cnt[s] != '0;
            w_in[s]       = w_flag[s] & ~w_full[s];
            w_cand[s]     = w_head_ok[s] | w_in[s];
            w_cand_id[s]  = w_head_ok[s] ? r_q_id[s][r_head[s]]  : w_in_id[s];
            w_cand_val[s] = w_head_ok[s] ? r_q_val[s][r_head[s]] : w_in_val[s];
        end
        w_win   = (&w_cand) ? ~r_last : w_cand[1];
        w_grant = (|w_cand) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
        w_pop   = w_grant & w_head_ok;
        // an incoming entry that wins on an empty queue bypasses straight to the CDB
        w_push  = w_in & ~(w_grant & ~w_head_ok);
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            r_cdb_flag <= 1'b0;
            r_cdb_id   <= '0;
            r_cdb_val  <= '0;
            r_last     <= LOAD;
            for (int s = 0; s < 2; s++) begin
                r_head[s] <= '0;
                r_tail[s] <= '0;
                r_cnt[s]  <= '0;
            end
        end else if (bus.readyIn) begin
            if (bus.clear) begin
                r_cdb_flag <= 1'b0;
                r_last     <= LOAD;
                for (int s = 0; s < 2; s++) begin
                    r_head[s] <= '0;
                    r_tail[s] <= '0;
                    r_cnt[s]  <= '0;
                end
            end else begin
                r_cdb_flag <= |w_cand;
                if (|w_cand) begin
                    r_cdb_id  <= w_cand_id[w_win];
                    r_cdb_val <= w_cand_val[w_win];
                    r_last    <= w_win;
                end
                for (int s = 0; s < 2; s++) begin
                    if (w_pop[s]) r_head[s] <= r_head[s] + PW'(1);
                    if (w_push[s]) r_tail[s] <= r_tail[s] + PW'(1);
                    r_cnt[s] <= r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
                end
            end
        end
    end

    always_ff @(posedge clockIn) begin
        if (bus.readyIn && !bus.clear) begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_q_id[s][r_tail[s]]  <= w_in_id[s];
                    r_q_val[s][r_tail[s]] <= w_in_val[s];
                end
            end
        end
    end

    assign bus.aluStall  = w_full[0];
    assign bus.loadStall = w_full[1];
    assign bus.cdbFlag   = r_cdb_flag;
    assign bus.cdbId     = r_cdb_id;
    assign bus.cdbValue  = r_cdb_val;
endmodule
